// File: rtl/mod_n_step_driver_pkg.sv
// Shared FSM state type and ring-distance helper for the mod-N step driver.
package mod_step_pkg;

   localparam int DEFAULT_MODULUS = 3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_STEP,
      S_GAP,
      S_FINISH
   } state_t;

   // Forward-only distance from cur to target on a ring of `modulus` states.
   function automatic int mod_diff(input int target, input int cur, input int modulus);
      return (target >= cur) ? (target - cur) : (target + modulus - cur);
   endfunction

endpackage

// File: rtl/mod_n_step_driver_step_gap_timer.sv
// Loadable down-counter holding off the next step pulse for GAP cycles.
// Latency: expired rises GAP cycles after load; no backpressure (free-running once loaded).
module step_gap_timer #(
   parameter int GAP = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic expired
);

   localparam int CW = (GAP > 0) ? $clog2(GAP + 1) : 1;

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= CW'(GAP - 1);
      end else if (count != '0) begin
         count <= count - CW'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/mod_n_step_driver.sv
// Steps a downstream mod-N counter to a commanded state and mirrors its state; owns its reset.
// Latency: first pulse 1 cycle after accept, done 2+(N-1)(STEP_GAP+1); cmd_ready low while busy.
module mod_n_step_driver
   import mod_step_pkg::*;
#(
   parameter int  MODULUS  = DEFAULT_MODULUS,
   parameter int  STEP_GAP = 0,
   localparam int W        = $clog2(MODULUS)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [W-1:0] cmd_target,
   input  logic         cmd_clear,
   output logic         step_out,
   output logic         ds_rst,
   output logic [W-1:0] mirror,
   output logic         predict_out,
   output logic         busy,
   output logic         done,
   output logic         cmd_err
);

   state_t       state;
   state_t       state_next;
   logic [W-1:0] rem;
   logic [W-1:0] n_steps;
   logic         accept;
   logic         illegal;
   logic         gap_expired;
   logic         step_d;
   logic         busy_d;
   logic         done_d;
   logic         ready_d;
   logic         err_d;

   assign accept      = (state == S_IDLE) && cmd_valid && cmd_ready;
   assign illegal     = int'(cmd_target) >= MODULUS;
   assign n_steps     = W'(mod_diff(int'(cmd_target), int'(mirror), MODULUS));
   assign predict_out = (mirror == W'(MODULUS - 1));

   generate
      if (STEP_GAP > 0) begin : g_gap
         step_gap_timer #(
            .GAP(STEP_GAP)
         ) u_gap_timer (
            .clk     (clk),
            .rst     (rst),
            .load    ((state == S_STEP) && (state_next == S_GAP)),
            .expired (gap_expired)
         );
      end else begin : g_no_gap
         assign gap_expired = 1'b1;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (cmd_clear) begin
         state_next = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept && !illegal) begin
                  state_next = (n_steps == '0) ? S_FINISH : S_STEP;
               end
            end
            S_STEP: begin
               if (rem == W'(1)) begin
                  state_next = S_FINISH;
               end else if (STEP_GAP > 0) begin
                  state_next = S_GAP;
               end else begin
                  state_next = S_STEP;
               end
            end
            S_GAP: begin
               if (gap_expired) begin
                  state_next = S_STEP;
               end
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so they can be registered without lag.
   always_comb begin
      step_d  = (state_next == S_STEP);
      busy_d  = (state_next != S_IDLE);
      done_d  = (state_next == S_FINISH);
      ready_d = (state_next == S_IDLE) && !cmd_clear;
      err_d   = accept && illegal && !cmd_clear;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         step_out  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cmd_ready <= 1'b0;
         cmd_err   <= 1'b0;
         ds_rst    <= 1'b1;
      end else begin
         step_out  <= step_d;
         busy      <= busy_d;
         done      <= done_d;
         cmd_ready <= ready_d;
         cmd_err   <= err_d;
         ds_rst    <= cmd_clear;
      end
   end

   // Mirror advances on the same edge the downstream counter absorbs each pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         mirror <= '0;
         rem    <= '0;
      end else if (cmd_clear) begin
         mirror <= '0;
         rem    <= '0;
      end else begin
         if (state == S_STEP) begin
            mirror <= (mirror == W'(MODULUS - 1)) ? '0 : mirror + W'(1);
            rem    <= rem - W'(1);
         end
         if (accept && !illegal) begin
            rem <= n_steps;
         end
      end
   end

endmodule
